conv_window_sched: RTL and testbench

CONV_WINDOW_SCHED -- requirements
Module: conv_window_sched

---
 rtl/conv_window_sched.sv | 146 ++++++++++++++
 tb/tb_conv_window_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched.sv
// 3-row sliding-window scheduler: streams image strips column-major from memory
// to a convolution engine and tags each engine result with its (row, col).
module conv_window_sched #(
  parameter int IMG_W           = 28,
  parameter int IMG_H           = 28,
  parameter int ADDR_W          = 10,
  parameter int PIXEL_WIDTH_OUT = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       frame_start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       mem_req_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_vld_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] mem_data_i,
  output logic                       conv_start_o,
  output logic                       conv_px_rdy_o,
  output logic [PIXEL_WIDTH_OUT-1:0] conv_px_o,
  input  logic                       conv_rdy_i,
  output logic [7:0]                 out_row_o,
  output logic [7:0]                 out_col_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [7:0] LAST_COL   = 8'(IMG_W - 1);
  localparam logic [7:0] RES_MAX    = 8'(IMG_W - 2);
  localparam logic [7:0] LAST_STRIP = 8'(IMG_H - 3);

  logic [2:0]                 state;
  logic [7:0]                 strip;
  logic [7:0]                 col;
  logic [1:0]                 k;
  logic [7:0]                 res_cnt;
  logic                       gap_cnt;
  logic [PIXEL_WIDTH_OUT-1:0] px_q;
  logic [7:0]                 row_q;
  logic [7:0]                 col_q;
  logic [ADDR_W-1:0]          addr_calc;
  logic                       busy_int;
  logic                       strip_on;

  always_comb begin
    addr_calc = (ADDR_W'(strip) + ADDR_W'(k)) * ADDR_W'(IMG_W) + ADDR_W'(col);
    busy_int  = (state != IDLE) && (state != DONE);
    strip_on  = (state == FETCH) || (state == WAIT) || (state == SEND) || (state == DRAIN);
  end

  // Outputs are masked by reset so they read zero during the reset cycle itself.
  always_comb begin
    busy_o        = !reset_i && busy_int;
    done_o        = !reset_i && (state == DONE);
    mem_req_o     = !reset_i && (state == FETCH);
    mem_addr_o    = (!reset_i && (state == FETCH)) ? addr_calc : '0;
    conv_start_o  = !reset_i && strip_on;
    conv_px_rdy_o = !reset_i && (state == SEND);
    conv_px_o     = reset_i ? '0 : px_q;
    out_row_o     = reset_i ? '0 : row_q;
    out_col_o     = reset_i ? '0 : col_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      strip   <= '0;
      col     <= '0;
      k       <= '0;
      res_cnt <= '0;
      gap_cnt <= 1'b0;
      px_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      // Result tagging sits before the FSM so the strip-change clear below wins.
      if (busy_int && conv_rdy_i && (res_cnt < RES_MAX)) begin
        row_q   <= strip;
        col_q   <= res_cnt;
        res_cnt <= res_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (frame_start_i) begin
            strip   <= '0;
            col     <= '0;
            k       <= '0;
            res_cnt <= '0;
            state   <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (mem_vld_i) begin
            px_q  <= mem_data_i;
            state <= SEND;
          end
        end
        SEND: begin
          if (k == 2'd2) begin
            k <= '0;
            if (col == LAST_COL) begin
              state <= DRAIN;
            end else begin
              col   <= col + 8'd1;
              state <= FETCH;
            end
          end else begin
            k     <= k + 2'd1;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (res_cnt == RES_MAX) begin
            gap_cnt <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt) begin
            if (strip == LAST_STRIP) begin
              state <= DONE;
            end else begin
              strip   <= strip + 8'd1;
              col     <= '0;
              k       <= '0;
              res_cnt <= '0;
              state   <= FETCH;
            end
          end else begin
            gap_cnt <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: a 5x4 instance for the main scenarios
// and a 3x3 instance for the minimum-size frame, sharing memory/engine models.
module tb_conv_window_sched;

  logic       clk = 1'b0;
  logic       reset, fs, mem_vld, conv_rdy, sel;
  logic [7:0] mem_data;

  logic       busy_a, done_a, mreq_a, cstart_a, pxrdy_a;
  logic [9:0] maddr_a;
  logic [7:0] px_a, orow_a, ocol_a;
  logic       busy_b, done_b, mreq_b, cstart_b, pxrdy_b;
  logic [9:0] maddr_b;
  logic [7:0] px_b, orow_b, ocol_b;

  logic       busy, done, mreq, cstart, pxrdy;
  logic [9:0] maddr;
  logic [7:0] px, orow, ocol;

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(5), .IMG_H(4), .ADDR_W(10), .PIXEL_WIDTH_OUT(8)) dut_a (
    .clk_i(clk), .reset_i(reset), .frame_start_i(fs && !sel), .busy_o(busy_a),
    .done_o(done_a), .mem_req_o(mreq_a), .mem_addr_o(maddr_a), .mem_vld_i(mem_vld),
    .mem_data_i(mem_data), .conv_start_o(cstart_a), .conv_px_rdy_o(pxrdy_a),
    .conv_px_o(px_a), .conv_rdy_i(conv_rdy), .out_row_o(orow_a), .out_col_o(ocol_a));

  conv_window_sched #(.IMG_W(3), .IMG_H(3), .ADDR_W(10), .PIXEL_WIDTH_OUT(8)) dut_b (
    .clk_i(clk), .reset_i(reset), .frame_start_i(fs && sel), .busy_o(busy_b),
    .done_o(done_b), .mem_req_o(mreq_b), .mem_addr_o(maddr_b), .mem_vld_i(mem_vld),
    .mem_data_i(mem_data), .conv_start_o(cstart_b), .conv_px_rdy_o(pxrdy_b),
    .conv_px_o(px_b), .conv_rdy_i(conv_rdy), .out_row_o(orow_b), .out_col_o(ocol_b));

  assign busy   = sel ? busy_b   : busy_a;
  assign done   = sel ? done_b   : done_a;
  assign mreq   = sel ? mreq_b   : mreq_a;
  assign maddr  = sel ? maddr_b  : maddr_a;
  assign cstart = sel ? cstart_b : cstart_a;
  assign pxrdy  = sel ? pxrdy_b  : pxrdy_a;
  assign px     = sel ? px_b     : px_a;
  assign orow   = sel ? orow_b   : orow_a;
  assign ocol   = sel ? ocol_b   : ocol_a;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int q_addr[$], q_px[$], q_row[$], q_col[$];
  int tw = 5, th = 4;
  int lat = 0;
  bit spur_vld = 0, spur_rdy = 0;
  int abort_at = -1;
  int rst_stage = 0;
  bit aborted = 0;
  bit pend = 0, rdy_exp = 0, prev_start = 0;
  int wcnt = 0, pend_addr = 0, strip_px = 0, strip_res = 0, low_run = 0, strip_idx = 0;
  int last_row = 0, last_col = 0;
  int n_reads = 0, n_px = 0, n_res = 0, n_done = 0;

  // Memory, engine and protocol monitor, all evaluated mid-cycle.
  initial begin
    mem_vld = 0; conv_rdy = 0; mem_data = '0;
    forever begin
      @(negedge clk);
      if (rst_stage == 1) begin
        check("rst_busy", int'(busy), 0);   check("rst_done", int'(done), 0);
        check("rst_req", int'(mreq), 0);    check("rst_addr", int'(maddr), 0);
        check("rst_start", int'(cstart), 0); check("rst_pxrdy", int'(pxrdy), 0);
        check("rst_px", int'(px), 0);       check("rst_row", int'(orow), 0);
        check("rst_col", int'(ocol), 0);
        reset = 0; rst_stage = 2;
        q_addr.delete(); q_px.delete(); q_row.delete(); q_col.delete();
        pend = 0; prev_start = 0; strip_px = 0; strip_res = 0; low_run = 0;
        last_row = 0; last_col = 0; mem_vld = 0; conv_rdy = 0; rdy_exp = 0;
      end else if (rst_stage == 2) begin
        check("abort_no_resume_busy", int'(busy), 0);
        check("abort_no_resume_req", int'(mreq), 0);
        rst_stage = 0; aborted = 1;
      end else if (!reset) begin
        if (conv_rdy) begin
          if (rdy_exp) begin
            if (q_row.size() == 0) check("result_extra", 1, 0);
            else begin
              last_row = q_row.pop_front(); last_col = q_col.pop_front();
              check("out_row", int'(orow), last_row);
              check("out_col", int'(ocol), last_col);
              n_res++; strip_res++;
            end
          end else begin
            check("ignored_rdy_row", int'(orow), last_row);
            check("ignored_rdy_col", int'(ocol), last_col);
          end
        end
        conv_rdy = 0; rdy_exp = 0; mem_vld = 0;
        if (mreq) begin
          check("one_outstanding", int'(pend), 0);
          n_reads++;
          if (q_addr.size() == 0) check("addr_extra", 1, 0);
          else check("mem_addr", int'(maddr), q_addr.pop_front());
          pend = 1; wcnt = lat; pend_addr = int'(maddr);
          if (spur_vld) begin mem_vld = 1; mem_data = 8'hEE; end
        end else if (pend) begin
          if (wcnt == 0) begin mem_vld = 1; mem_data = 8'(pend_addr); pend = 0; end
          else wcnt--;
        end
        if (cstart && !prev_start) begin
          if (strip_idx > 0) check("gap_len", low_run, 2);
          low_run = 0; strip_idx++; strip_px = 0; strip_res = 0;
        end
        if (busy && !cstart) begin
          low_run++;
          check("gap_no_req", int'(mreq), 0);
          check("gap_no_px", int'(pxrdy), 0);
          if (prev_start) check("gap_after_results", strip_res, tw - 2);
        end
        prev_start = cstart;
        if (pxrdy) begin
          if (q_px.size() == 0) check("px_extra", 1, 0);
          else check("conv_px", int'(px), q_px.pop_front());
          n_px++; strip_px++;
          // Engine: one result per completed column once three columns are in.
          if (strip_px % 3 == 0 && strip_px >= 9) begin conv_rdy = 1; rdy_exp = 1; end
          if (n_px == abort_at) begin reset = 1; rst_stage = 1; end
        end
        if (done) begin
          n_done++;
          check("done_busy_low", int'(busy), 0);
          check("gap_len_last", low_run, 2);
          low_run = 0;
        end
        if (spur_rdy && !conv_rdy && (!busy || !cstart)) conv_rdy = 1;
      end
    end
  end

  task automatic start_frame();
    n_reads = 0; n_px = 0; n_res = 0; n_done = 0; strip_idx = 0;
    for (int s = 0; s <= th - 3; s++)
      for (int c = 0; c < tw; c++)
        for (int k = 0; k < 3; k++) begin
          q_addr.push_back((s + k) * tw + c);
          q_px.push_back((s + k) * tw + c);
        end
    for (int s = 0; s <= th - 3; s++)
      for (int c = 0; c < tw - 2; c++) begin
        q_row.push_back(s); q_col.push_back(c);
      end
    @(negedge clk); fs = 1;
    @(negedge clk); fs = 0;
  endtask

  task automatic run_frame();
    int guard = 0;
    while (n_done == 0 && guard < 3000) begin @(negedge clk); #1; guard++; end
    repeat (10) @(negedge clk);
    #1;
    check("done_count", n_done, 1);
    check("reads", n_reads, 3 * tw * (th - 2));
    check("pixels", n_px, 3 * tw * (th - 2));
    check("results", n_res, (th - 2) * (tw - 2));
    check("strips", strip_idx, th - 2);
    check("idle_after", int'(busy), 0);
    check("addr_left", q_addr.size(), 0);
    check("px_left", q_px.size(), 0);
    check("res_left", q_row.size(), 0);
  endtask

  initial begin
    reset = 1; fs = 0; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", int'(busy), 0);   check("reset_req", int'(mreq), 0);
    check("reset_addr", int'(maddr), 0);  check("reset_start", int'(cstart), 0);
    check("reset_pxrdy", int'(pxrdy), 0); check("reset_px", int'(px), 0);
    check("reset_row", int'(orow), 0);    check("reset_col", int'(ocol), 0);
    check("reset_done", int'(done), 0);
    reset = 0;
    repeat (2) @(negedge clk);

    lat = 0; start_frame(); run_frame();
    lat = 3; spur_rdy = 1; start_frame(); run_frame();
    spur_rdy = 0; lat = 0; spur_vld = 1;
    start_frame();
    repeat (20) @(negedge clk);
    fs = 1; @(negedge clk); fs = 0;
    run_frame();
    spur_vld = 0;

    abort_at = 17; aborted = 0;
    start_frame();
    for (int g = 0; g < 1000 && !aborted; g++) begin @(negedge clk); #1; end
    check("abort_seen", int'(aborted), 1);
    abort_at = -1;
    start_frame(); run_frame();

    sel = 1; tw = 3; th = 3;
    repeat (2) @(negedge clk);
    start_frame(); run_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
